// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the pipeline-side signals that the hazard controller observes and
// the stall/bubble/counter signals that it drives.
//   master : pipeline side (drives stage information, receives controls)
//   slave  : hazard controller (receives stage information, drives controls)
// Signals:
//   rs1_id, rs2_id           ID-stage source registers
//   rs1_used_id, rs2_used_id ID instruction reads rs1 / rs2
//   rd_ex                    EX-stage destination register
//   mem_read_ex              EX instruction is a load
//   branch_taken_ex          EX redirect (taken branch or jump)
//   mem_req_mem              MEM instruction accesses data memory
//   mem_ready                data memory completes the access this cycle
//   stall_*                  hold the corresponding stage register
//   bubble_*                 load the default value into the stage register
//   cnt_*                    16-bit saturating event counters
//   mem_timeout              sticky memory-wait watchdog flag
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  logic [4:0]  rd_ex;
  logic        mem_read_ex;
  logic        branch_taken_ex;
  logic        mem_req_mem;
  logic        mem_ready;

  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        stall_mem;
  logic        stall_wb;
  logic        bubble_id;
  logic        bubble_ex;
  logic        bubble_mem;
  logic        bubble_wb;
  logic [15:0] cnt_mem_wait;
  logic [15:0] cnt_load_use;
  logic [15:0] cnt_flush;
  logic        mem_timeout;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex,
           mem_read_ex, branch_taken_ex, mem_req_mem, mem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, stall_wb,
           bubble_id, bubble_ex, bubble_mem, bubble_wb,
           cnt_mem_wait, cnt_load_use, cnt_flush, mem_timeout
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex,
           mem_read_ex, branch_taken_ex, mem_req_mem, mem_ready,
    output stall_if, stall_id, stall_ex, stall_mem, stall_wb,
           bubble_id, bubble_ex, bubble_mem, bubble_wb,
           cnt_mem_wait, cnt_load_use, cnt_flush, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a five-stage pipeline. Resolves memory-wait stalls,
// load-use stalls and taken-branch flushes with priority
// memory hazard > branch flush > load-use. Stall/bubble controls are
// combinational so they act in the same cycle as the hazard. A two-state FSM
// (RUN / MEM_WAIT) with a saturating wait counter feeds a sticky watchdog.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    pipe_hazard_ctrl_if.slave (stage info in, controls/counters out)
// Parameters:
//   WD_LIMIT  memory-wait watchdog limit in cycles (must fit in 7 bits)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned WD_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [6:0]  WD_LIM7  = 7'(WD_LIMIT);
  localparam logic [6:0]  WCNT_MAX = 7'h7F;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      state_q;
  logic [6:0]  wcnt_q;
  logic [15:0] cnt_mem_wait_q, cnt_mem_wait_d;
  logic [15:0] cnt_load_use_q, cnt_load_use_d;
  logic [15:0] cnt_flush_q, cnt_flush_d;
  logic        mem_timeout_q;

  logic mem_hazard;
  logic load_use;
  logic flush_apply;
  logic lu_apply;

  // Hazard detection. x0 is hard-wired zero, so a load targeting it never
  // creates a dependency.
  always_comb begin
    mem_hazard  = bus.mem_req_mem & ~bus.mem_ready;
    load_use    = bus.mem_read_ex && (bus.rd_ex != 5'd0) &&
                  ((bus.rs1_used_id && (bus.rs1_id == bus.rd_ex)) ||
                   (bus.rs2_used_id && (bus.rs2_id == bus.rd_ex)));
    // A branch seen during a memory wait is held in EX, so it is applied
    // in the release cycle rather than lost.
    flush_apply = bus.branch_taken_ex & ~mem_hazard;
    // The flush kills the dependent instruction, so load-use is moot then.
    lu_apply    = load_use & ~mem_hazard & ~bus.branch_taken_ex;
  end

  // Stage controls. During reset every stage is loaded with its default.
  always_comb begin
    bus.stall_if   = 1'b0;
    bus.stall_id   = 1'b0;
    bus.stall_ex   = 1'b0;
    bus.stall_mem  = 1'b0;
    bus.stall_wb   = 1'b0;
    bus.bubble_id  = 1'b0;
    bus.bubble_ex  = 1'b0;
    bus.bubble_mem = 1'b0;
    bus.bubble_wb  = 1'b0;
    if (!rst_n) begin
      bus.bubble_id  = 1'b1;
      bus.bubble_ex  = 1'b1;
      bus.bubble_mem = 1'b1;
      bus.bubble_wb  = 1'b1;
    end else if (mem_hazard) begin
      // Freeze IF..MEM; WB gets a bubble since MEM produces nothing.
      bus.stall_if  = 1'b1;
      bus.stall_id  = 1'b1;
      bus.stall_ex  = 1'b1;
      bus.stall_mem = 1'b1;
      bus.bubble_wb = 1'b1;
    end else if (flush_apply) begin
      bus.bubble_id = 1'b1;
      bus.bubble_ex = 1'b1;
    end else if (lu_apply) begin
      // One bubble suffices: the load moves on to MEM next cycle.
      bus.stall_if  = 1'b1;
      bus.stall_id  = 1'b1;
      bus.bubble_ex = 1'b1;
    end
  end

  // Saturating counter next values.
  always_comb begin
    cnt_mem_wait_d = cnt_mem_wait_q;
    cnt_load_use_d = cnt_load_use_q;
    cnt_flush_d    = cnt_flush_q;
    if (mem_hazard && (cnt_mem_wait_q != CNT_MAX)) begin
      cnt_mem_wait_d = cnt_mem_wait_q + 16'd1;
    end
    if (lu_apply && (cnt_load_use_q != CNT_MAX)) begin
      cnt_load_use_d = cnt_load_use_q + 16'd1;
    end
    if (flush_apply && (cnt_flush_q != CNT_MAX)) begin
      cnt_flush_d = cnt_flush_q + 16'd1;
    end
  end

  // FSM, wait counter, watchdog and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wcnt_q         <= 7'd0;
      cnt_mem_wait_q <= 16'd0;
      cnt_load_use_q <= 16'd0;
      cnt_flush_q    <= 16'd0;
      mem_timeout_q  <= 1'b0;
    end else begin
      cnt_mem_wait_q <= cnt_mem_wait_d;
      cnt_load_use_q <= cnt_load_use_d;
      cnt_flush_q    <= cnt_flush_d;

      if ((state_q == MEM_WAIT) && (wcnt_q >= WD_LIM7)) begin
        mem_timeout_q <= 1'b1;
      end

      case (state_q)
        RUN: begin
          if (mem_hazard) begin
            state_q <= MEM_WAIT;
            wcnt_q  <= 7'd1;
          end
        end
        MEM_WAIT: begin
          // Either completion or an abandoned request ends the wait.
          if (bus.mem_ready || !bus.mem_req_mem) begin
            state_q <= RUN;
            wcnt_q  <= 7'd0;
          end else if (wcnt_q != WCNT_MAX) begin
            wcnt_q <= wcnt_q + 7'd1;
          end
        end
        default: begin
          state_q <= RUN;
          wcnt_q  <= 7'd0;
        end
      endcase
    end
  end

  assign bus.cnt_mem_wait = cnt_mem_wait_q;
  assign bus.cnt_load_use = cnt_load_use_q;
  assign bus.cnt_flush    = cnt_flush_q;
  assign bus.mem_timeout  = mem_timeout_q;

endmodule
